// File: rtl/qed_inst_pkg.sv
// Shared opcode, funct and LFSR constants plus the class and FSM enums for qed_inst_gen.
// Also holds the small funct3 legalisation helpers used during field assembly.
package qed_inst_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_NOP    = 7'b1111111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;
  localparam logic [31:0] INST_ECALL  = {25'h0, OP_SYSTEM};
  localparam logic [31:0] INST_EBREAK = {12'h001, 13'h0, OP_SYSTEM};
  localparam logic [31:0] INST_NOP    = {25'h1FF_FFFF, OP_NOP};

  typedef enum logic [3:0] {
    ClsR, ClsI, ClsLoad, ClsStore, ClsBranch, ClsJal, ClsLui, ClsAuipc, ClsSystem, ClsNop
  } inst_class_e;

  typedef enum logic [1:0] {StIdle, StRun, StDone} gen_state_e;

  // Loads never use the reserved widths: 011->LW, 110->LBU, 111->LHU.
  function automatic logic [2:0] load_f3(input logic [2:0] f3);
    case (f3)
      3'b011:  return F3_LW;
      3'b110:  return F3_LBU;
      3'b111:  return F3_LHU;
      default: return f3;
    endcase
  endfunction

  // Stores fold onto SB/SH/SW using the low funct3 bits; 11 becomes SW.
  function automatic logic [2:0] store_f3(input logic [1:0] f3_lo);
    return (f3_lo == 2'b11) ? F3_LW : {1'b0, f3_lo};
  endfunction

  function automatic logic [2:0] branch_f3(input logic [2:0] f3);
    return (f3[2:1] == 2'b01) ? {2'b00, f3[0]} : f3;
  endfunction

endpackage

// File: rtl/qed_inst_gen_if.sv
// Instruction fetch handshake between the generator (master) and the DUT fetch port (slave).
interface qed_inst_gen_if;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;

  modport master (output inst_valid, output instruction, input inst_ready);
  modport slave  (input inst_valid, input instruction, output inst_ready);
endinterface

// File: rtl/qed_lfsr32.sv
// 32-bit right-shifting Galois LFSR; load takes priority over advance, a zero seed becomes 1.
module qed_lfsr32
  import qed_inst_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        advance,
  input  logic [31:0] seed,
  output logic [31:0] state
);

  logic [31:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (seed == 32'h0) ? 32'h1 : seed;
    end else if (advance) begin
      state_d = {1'b0, state_q[31:1]} ^ (state_q[0] ? LFSR_TAPS : 32'h0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= 32'h1;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/qed_inst_gen.sv
// Constrained-random RV32I instruction source obeying the QED legality rules.
// Define QED_INST_GEN_STORE_EN to emit stores once the DUT has signalled SIF commit.
module qed_inst_gen
  import qed_inst_pkg::*;
#(
  parameter int unsigned NUM_INSTS = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [31:0]           seed,
  input  logic                  sif_commit,
  qed_inst_gen_if.master        inst_if,
  output logic [31:0]           inst_count,
  output logic                  done
);

`ifdef QED_INST_GEN_STORE_EN
  localparam bit StoreEn = 1'b1;
`else
  localparam bit StoreEn = 1'b0;
`endif

  gen_state_e  state_q, state_d;
  logic [31:0] count_q, count_d;
  logic        store_ok_q, store_ok_d;
  logic [31:0] lfsr;
  logic        handshake, start_run, last_inst, emit_store;

  assign handshake  = inst_if.inst_valid && inst_if.inst_ready;
  assign start_run  = start && (state_q != StRun);
  assign last_inst  = (NUM_INSTS != 0) && (count_q + 32'd1 == NUM_INSTS);
  assign emit_store = StoreEn && store_ok_q;

  qed_lfsr32 u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (start_run),
    .advance (handshake),
    .seed    (seed),
    .state   (lfsr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      count_q    <= 32'h0;
      store_ok_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      store_ok_q <= store_ok_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StRun;
      StRun:          if (handshake && last_inst) state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  always_comb begin
    inst_if.inst_valid = (state_q == StRun);
    done               = (state_q == StDone);
  end

  // store_ok only moves on start or handshake so a stall never changes the offered word.
  always_comb begin
    count_d    = count_q;
    store_ok_d = store_ok_q;
    if (start_run) begin
      count_d    = 32'h0;
      store_ok_d = sif_commit;
    end else if (handshake) begin
      count_d    = count_q + 32'd1;
      store_ok_d = store_ok_q | sif_commit;
    end
  end

  assign inst_count = count_q;

  inst_class_e cls;
  logic [3:0]  sel;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [6:0]  r_f7;
  logic [11:0] i_imm;
  logic        unused_lfsr_bits;

  assign sel = lfsr[31:28];
  assign f3  = lfsr[14:12];
  assign rd  = {1'b0, lfsr[10:7]};
  assign rs1 = {1'b0, lfsr[18:15]};
  assign rs2 = {1'b0, lfsr[23:20]};
  assign unused_lfsr_bits = ^{lfsr[19], lfsr[6:0]};

  always_comb begin
    cls = ClsNop;
    case (sel)
      4'd0, 4'd1, 4'd2, 4'd3: cls = ClsR;
      4'd4, 4'd5, 4'd6:       cls = ClsI;
      4'd7, 4'd8:             cls = ClsLoad;
      4'd9, 4'd10:            cls = emit_store ? ClsStore : ClsLoad;
      4'd11:                  cls = ClsBranch;
      4'd12:                  cls = ClsJal;
      4'd13:                  cls = ClsLui;
      4'd14:                  cls = ClsAuipc;
      4'd15:                  cls = lfsr[27] ? ClsSystem : ClsNop;
    endcase
  end

  always_comb begin
    r_f7 = ((f3 == F3_ADD || f3 == F3_SR) && lfsr[26]) ? F7_ALT : F7_ZERO;
    case (f3)
      F3_SLL:  i_imm = {F7_ZERO, lfsr[24:20]};
      F3_SR:   i_imm = {(lfsr[26] ? F7_ALT : F7_ZERO), lfsr[24:20]};
      default: i_imm = lfsr[31:20];
    endcase
  end

  always_comb begin
    inst_if.instruction = INST_NOP;
    unique case (cls)
      ClsR:      inst_if.instruction = {r_f7, rs2, rs1, f3, rd, OP_R};
      ClsI:      inst_if.instruction = {i_imm, rs1, f3, rd, OP_I};
      ClsLoad:   inst_if.instruction = {6'b0, lfsr[25:20], 5'd0, load_f3(f3), rd, OP_LOAD};
      ClsStore:  inst_if.instruction = {6'b0, lfsr[25], rs2, 5'd0, store_f3(f3[1:0]),
                                        lfsr[11:7], OP_STORE};
      ClsBranch: inst_if.instruction = {lfsr[31:25], rs2, rs1, branch_f3(f3), lfsr[11:7],
                                        OP_BRANCH};
      ClsJal:    inst_if.instruction = {lfsr[31:12], 5'd0, OP_JAL};
      ClsLui:    inst_if.instruction = {lfsr[31:12], rd, OP_LUI};
      ClsAuipc:  inst_if.instruction = {lfsr[31:12], 5'd0, OP_AUIPC};
      ClsSystem: inst_if.instruction = lfsr[26] ? INST_EBREAK : INST_ECALL;
      ClsNop:    inst_if.instruction = INST_NOP;
      default:   inst_if.instruction = INST_NOP;
    endcase
  end

endmodule

// File: tb/tb_qed_inst_gen.sv
// Self-checking bench for qed_inst_gen: seed-driven vector table, directed corner sequences and
// randomized runs compared against an arithmetic reference model of the generation rules.
module tb_qed_inst_gen;

  localparam int unsigned NUM = 8;
`ifdef QED_INST_GEN_STORE_EN
  localparam bit STORE_EN = 1'b1;
`else
  localparam bit STORE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] seed = 32'h0;
  logic        sif_commit = 1'b0;
  logic [31:0] inst_count;
  logic        done;

  qed_inst_gen_if inst_if ();

  qed_inst_gen #(.NUM_INSTS(NUM)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .seed       (seed),
    .sif_commit (sif_commit),
    .inst_if    (inst_if),
    .inst_count (inst_count),
    .done       (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int stores = 0;

  // Reference model state: 0 idle, 1 run, 2 done.
  int          m_state = 0;
  logic [31:0] m_lfsr = 32'h1;
  bit          m_sok = 1'b0;
  logic [31:0] m_count = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] l, input bit sok);
    int unsigned sel, f3, rd, rs1, rs2, f7, imm;
    bit alt;
    sel = l >> 28;
    f3  = (l >> 12) & 7;
    rd  = (l >> 7) & 15;
    rs1 = (l >> 15) & 15;
    rs2 = (l >> 20) & 15;
    alt = l[26];
    if (sel >= 9 && sel <= 10 && !(STORE_EN && sok)) sel = 7;
    if (sel <= 3) begin
      f7 = ((f3 == 0 || f3 == 5) && alt) ? 32 : 0;
      return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
    end else if (sel <= 6) begin
      imm = l >> 20;
      if (f3 == 1) imm = (l >> 20) & 31;
      else if (f3 == 5) imm = (alt ? 1024 : 0) + ((l >> 20) & 31);
      return (imm << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
    end else if (sel <= 8) begin
      if (f3 == 3) f3 = 2;
      else if (f3 >= 6) f3 = f3 - 2;
      return (((l >> 20) & 63) << 20) | (f3 << 12) | (rd << 7) | 32'h03;
    end else if (sel <= 10) begin
      f3 = f3 & 3;
      if (f3 == 3) f3 = 2;
      return ((l[25] ? 1 : 0) << 25) | (rs2 << 20) | (f3 << 12) | (l & 32'hF80) | 32'h23;
    end else if (sel == 11) begin
      if (f3 == 2 || f3 == 3) f3 = f3 - 2;
      return (l & 32'hFE00_0000) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (l & 32'hF80)
             | 32'h63;
    end else if (sel == 12) begin
      return (l & 32'hFFFF_F000) | 32'h6F;
    end else if (sel == 13) begin
      return (l & 32'hFFFF_F000) | (rd << 7) | 32'h37;
    end else if (sel == 14) begin
      return (l & 32'hFFFF_F000) | 32'h17;
    end
    if (!l[27]) return 32'hFFFF_FFFF;
    return alt ? 32'h0010_0073 : 32'h0000_0073;
  endfunction

  // Legality of a word judged only from its encoding.
  function automatic bit legal(input logic [31:0] w);
    logic [2:0] f3;
    f3 = w[14:12];
    case (w[6:0])
      7'h33: return !w[19] && !w[24] && !w[11] &&
                    (w[31:25] == 0 || (w[31:25] == 7'h20 && (f3 == 0 || f3 == 5)));
      7'h13: return !w[19] && !w[11] && (f3 != 1 || w[31:25] == 0) &&
                    (f3 != 5 || w[31:25] == 0 || w[31:25] == 7'h20);
      7'h03: return w[19:15] == 0 && w[31:26] == 0 && !w[11] && f3 != 3 && f3 < 6;
      7'h23: return STORE_EN && w[19:15] == 0 && w[31:26] == 0 && !w[24] && f3 <= 2;
      7'h63: return !w[19] && !w[24] && f3 != 2 && f3 != 3;
      7'h6F, 7'h17: return w[11:7] == 0;
      7'h37: return !w[11];
      7'h73: return w == 32'h73 || w == 32'h0010_0073;
      7'h7F: return w == 32'hFFFF_FFFF;
      default: return 1'b0;
    endcase
  endfunction

  // One clock: drive at negedge, check 1ns later, then advance the model past the posedge.
  task automatic cycle(input bit st, input logic [31:0] sd, input bit sif, input bit rdy);
    @(negedge clk);
    start = st;
    seed = sd;
    sif_commit = sif;
    inst_if.inst_ready = rdy;
    #1;
    chk("valid", {31'b0, inst_if.inst_valid}, {31'b0, m_state == 1});
    chk("done", {31'b0, done}, {31'b0, m_state == 2});
    chk("count", inst_count, m_count);
    if (m_state == 1) begin
      chk("word", inst_if.instruction, model_word(m_lfsr, m_sok));
      chk("legal", {31'b0, legal(inst_if.instruction)}, 32'h1);
      if (inst_if.instruction[6:0] == 7'h23) stores++;
      if (rdy) begin
        m_lfsr = lfsr_step(m_lfsr);
        m_sok = m_sok | sif;
        m_count++;
        if (m_count == NUM) m_state = 2;
      end
    end else if (st) begin
      m_lfsr = (sd == 0) ? 32'h1 : sd;
      m_count = 0;
      m_sok = sif;
      m_state = 1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    inst_if.inst_ready = 1'b0;
    #1;
    chk("rst_valid", {31'b0, inst_if.inst_valid}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_count", inst_count, 32'h0);
    m_state = 0;
    m_lfsr = 32'h1;
    m_sok = 1'b0;
    m_count = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0] seed;
    bit          sif;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic [31:0] exp0;
    int mode;

    tbl[0]  = '{32'h0000_0000, 1'b0, 32'h0000_0033};
    tbl[1]  = '{32'h0400_5000, 1'b0, 32'h4000_5033};
    tbl[2]  = '{32'h4400_5000, 1'b0, 32'h4000_5013};
    tbl[3]  = '{32'h7FFF_FFFF, 1'b0, 32'h03F0_5783};
    tbl[4]  = '{32'h9FFF_FFFF, 1'b0, 32'h03F0_5783};
    tbl[5]  = '{32'h9FFF_FFFF, 1'b1, STORE_EN ? 32'h02F0_2FA3 : 32'h03F0_5783};
    tbl[6]  = '{32'hB000_3000, 1'b0, 32'hB000_1063};
    tbl[7]  = '{32'hC000_0000, 1'b0, 32'hC000_006F};
    tbl[8]  = '{32'hD123_4580, 1'b0, 32'hD123_45B7};
    tbl[9]  = '{32'hE123_4FFF, 1'b0, 32'hE123_4017};
    tbl[10] = '{32'hF800_0000, 1'b0, 32'h0000_0073};
    tbl[11] = '{32'hFC00_0000, 1'b0, 32'h0010_0073};
    tbl[12] = '{32'hF000_0000, 1'b0, 32'hFFFF_FFFF};

    inst_if.inst_ready = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    foreach (tbl[i]) begin
      do_reset();
      cycle(1'b1, tbl[i].seed, tbl[i].sif, 1'b0);
      cycle(1'b0, 32'h0, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_word", i), inst_if.instruction, tbl[i].exp);
    end

    // Seed 0 behaves as lfsr=1; first handshake bumps the count to 1.
    do_reset();
    cycle(1'b1, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    chk("seed0_word", inst_if.instruction, 32'h0000_0033);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    chk("first_count", inst_count, 32'h1);

    // Stall with sif_commit toggling: offered word must hold.
    exp0 = model_word(m_lfsr, m_sok);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 32'h0, k[0], 1'b0);
      chk("stall_word", inst_if.instruction, exp0);
      chk("stall_valid", {31'b0, inst_if.inst_valid}, 32'h1);
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);

    // Run to completion, then restart.
    for (int k = 0; k < 20 && m_state == 1; k++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    chk("done_flag", {31'b0, done}, 32'h1);
    chk("done_valid", {31'b0, inst_if.inst_valid}, 32'h0);
    chk("done_count", inst_count, NUM);
    cycle(1'b1, 32'h1234_5678, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("restart_count", inst_count, 32'h0);
    chk("restart_valid", {31'b0, inst_if.inst_valid}, 32'h1);

    // Randomized runs: sif_commit held low, random, or high; stray starts mid-run.
    for (int r = 0; r < 300; r++) begin
      mode = r % 3;
      cycle(1'b1, $urandom, mode == 2 || (mode == 1 && $urandom_range(1, 0) == 1), 1'b1);
      for (int c = 0; c < 200 && m_state == 1; c++) begin
        cycle($urandom_range(15, 0) == 0, $urandom,
              mode == 2 || (mode == 1 && $urandom_range(3, 0) == 0),
              $urandom_range(3, 0) != 0);
      end
    end

    // Store presence follows the build option when commit is signalled from the start.
    stores = 0;
    for (int r = 0; r < 40; r++) begin
      cycle(1'b1, $urandom, 1'b1, 1'b1);
      for (int c = 0; c < 20 && m_state == 1; c++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    end
    chk("stores_present", {31'b0, stores > 0}, {31'b0, STORE_EN});
    stores = 0;
    for (int r = 0; r < 40; r++) begin
      cycle(1'b1, $urandom, 1'b0, 1'b1);
      for (int c = 0; c < 20 && m_state == 1; c++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
    end
    chk("no_store_wo_commit", stores, 32'h0);

    // Asynchronous reset while an instruction is offered and stalled.
    cycle(1'b1, 32'hCAFE_F00D, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("pre_rst_valid", {31'b0, inst_if.inst_valid}, 32'h1);
    do_reset();
    for (int k = 0; k < 3; k++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    chk("idle_valid", {31'b0, inst_if.inst_valid}, 32'h0);
    cycle(1'b1, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("post_rst_word", inst_if.instruction, 32'h0000_0033);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
